// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Holds the power-state encoding and the macro wake-up length used by the FSM.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2
  } mem_ctrl_state_t;

  // The bank needs this many cycles with chip_en high before it accepts an access.
  localparam int MEM_WAKE_CYCLES = 1;
  localparam int WAKE_CW         = 2;

  function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
    return addr < 32'(depth);
  endfunction

endpackage

// File: rtl/memory_interface.sv
// Single-bank memory link: write side carries chip_en, read side returns data.
// Bank-side modports let the bank model sit on the same instance as the initiator.
interface MemoryInterface #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic              chip_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport write_bank_out (output wr_en, chip_en, wr_addr, wr_data);
  modport read_bank_out  (output rd_en, rd_addr, input rd_data);
  modport write_bank_in  (input wr_en, chip_en, wr_addr, wr_data);
  modport read_bank_in   (input rd_en, rd_addr, output rd_data);

endinterface

// File: rtl/mem_access_ctrl_idle_timer.sv
// mem_idle_timer: saturating idle counter; expired flags the last idle cycle before power-down.
// IDLE_TIMEOUT = 0 disables expiry entirely.
module mem_idle_timer #(
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int CW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (IDLE_TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for one memory bank: client valid/ready requests, registered read response, idle power gating.
// Optional address range checking with bounds_err output is enabled by MEM_ACCESS_CTRL_BOUNDS_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter  int DEPTH        = 1024,
  parameter  int DATA_W       = 16,
  parameter  int IDLE_TIMEOUT = 8,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  output logic              bounds_err,
`endif
  MemoryInterface.write_bank_out mem_write,
  MemoryInterface.read_bank_out  mem_read
);

  mem_ctrl_state_t      state;
  mem_ctrl_state_t      state_next;
  logic [WAKE_CW-1:0]   wake_cnt;
  logic                 handshake;
  logic                 addr_ok;
  logic                 do_write;
  logic                 do_read;
  logic                 idle_clear;
  logic                 idle_expired;

  assign req_ready = (state == ON);
  assign handshake = req_valid & req_ready;

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  assign addr_ok = addr_in_range(32'(req_addr), DEPTH);
`else
  assign addr_ok = 1'b1;
`endif

  assign do_write = handshake & req_we & addr_ok;
  assign do_read  = handshake & ~req_we & addr_ok;

  // Bank signals follow the accepted request combinationally and sit at zero otherwise.
  assign mem_write.chip_en = (state != OFF);
  assign mem_write.wr_en   = do_write;
  assign mem_write.wr_addr = do_write ? req_addr : '0;
  assign mem_write.wr_data = do_write ? req_wdata : '0;
  assign mem_read.rd_en    = do_read;
  assign mem_read.rd_addr  = do_read ? req_addr : '0;

  assign idle_clear = handshake | (state != ON);

  mem_idle_timer #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (idle_clear),
    .expired (idle_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt <= '0;
    end else if (state == WAKE) begin
      wake_cnt <= wake_cnt + WAKE_CW'(1);
    end else begin
      wake_cnt <= '0;
    end
  end

  // A pending client request or an in-flight response keeps the bank powered.
  always_comb begin
    state_next = state;
    case (state)
      OFF: begin
        if (req_valid) state_next = WAKE;
      end
      WAKE: begin
        if (wake_cnt == WAKE_CW'(MEM_WAKE_CYCLES - 1)) state_next = ON;
      end
      ON: begin
        if (idle_expired && !req_valid && !rsp_valid) state_next = OFF;
      end
      default: state_next = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= do_read;
      if (do_read) rsp_data <= mem_read.rd_data;
    end
  end

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bounds_err <= 1'b0;
    end else begin
      bounds_err <= handshake & ~addr_ok;
    end
  end
`endif

  a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_write.wr_en && mem_read.rd_en));

  a_no_access_unpowered: assert property (@(posedge clk) disable iff (!rst_n)
    !((mem_write.wr_en || mem_read.rd_en) && !mem_write.chip_en));

  a_ready_only_on: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_ready && (state != ON)));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a combinational-read bank model.
// Defining MEM_ACCESS_CTRL_BOUNDS_CHECK_EN switches to DEPTH=1000 and adds the out-of-range read case.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  localparam int DEPTH = 1000;
`else
  localparam int DEPTH = 1024;
`endif
  localparam int DATA_W = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
  logic              bounds_err;
`endif

  int checks = 0;
  int passes = 0;

  MemoryInterface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  mem_access_ctrl #(
    .DEPTH        (DEPTH),
    .DATA_W       (DATA_W),
    .IDLE_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
    .bounds_err (bounds_err),
`endif
    .mem_write  (mem_if),
    .mem_read   (mem_if)
  );

  always #5 clk = ~clk;

  // Bank model: writes land on the clock edge, reads are combinational.
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_if.chip_en && mem_if.wr_en) mem[mem_if.wr_addr] <= mem_if.wr_data;
  end
  assign mem_if.rd_data = mem[mem_if.rd_addr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    req_valid = valid;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_chip_en", 32'(mem_if.chip_en), 32'd0);
    checkOutput("reset_wr_en", 32'(mem_if.wr_en), 32'd0);
    checkOutput("reset_rd_en", 32'(mem_if.rd_en), 32'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("reset_state", 32'(dut.state), 32'(OFF));

    // Wake-up path: OFF -> WAKE -> ON with the read accepted in ON
    applyStimulus(1'b1, 1'b0, ADDR_W'(5), '0);
    checkOutput("off_chip_en", 32'(mem_if.chip_en), 32'd0);
    checkOutput("off_req_ready", 32'(req_ready), 32'd0);
    nextCycle();
    checkOutput("wake_state", 32'(dut.state), 32'(WAKE));
    checkOutput("wake_chip_en", 32'(mem_if.chip_en), 32'd1);
    checkOutput("wake_req_ready", 32'(req_ready), 32'd0);
    checkOutput("wake_rd_en", 32'(mem_if.rd_en), 32'd0);
    nextCycle();
    checkOutput("on_state", 32'(dut.state), 32'(ON));
    checkOutput("on_req_ready", 32'(req_ready), 32'd1);
    checkOutput("on_rd_en", 32'(mem_if.rd_en), 32'd1);
    checkOutput("on_rd_addr", 32'(mem_if.rd_addr), 32'd5);
    checkOutput("on_wr_en", 32'(mem_if.wr_en), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("first_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("idle_rd_en", 32'(mem_if.rd_en), 32'd0);
    nextCycle();
    checkOutput("rsp_pulse_end", 32'(rsp_valid), 32'd0);

    // Write then read the same address on consecutive cycles
    applyStimulus(1'b1, 1'b1, ADDR_W'(12), 16'hBEEF);
    checkOutput("wr_en", 32'(mem_if.wr_en), 32'd1);
    checkOutput("wr_rd_en", 32'(mem_if.rd_en), 32'd0);
    checkOutput("wr_addr", 32'(mem_if.wr_addr), 32'd12);
    checkOutput("wr_data", 32'(mem_if.wr_data), 32'hBEEF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, ADDR_W'(12), '0);
    checkOutput("raw_rd_en", 32'(mem_if.rd_en), 32'd1);
    checkOutput("raw_wr_en", 32'(mem_if.wr_en), 32'd0);
    checkOutput("raw_no_rsp", 32'(rsp_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("raw_rsp_data", 32'(rsp_data), 32'hBEEF);

    // Preload 0..3, then stream four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, ADDR_W'(i), DATA_W'(16'h10 + i));
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, ADDR_W'(i), '0);
      if (i > 0) begin
        checkOutput($sformatf("stream_valid_%0d", i - 1), 32'(rsp_valid), 32'd1);
        checkOutput($sformatf("stream_data_%0d", i - 1), 32'(rsp_data), 32'h10 + 32'(i - 1));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("stream_valid_3", 32'(rsp_valid), 32'd1);
    checkOutput("stream_data_3", 32'(rsp_data), 32'h13);
    nextCycle();
    checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("hold_rsp_data", 32'(rsp_data), 32'h13);

    // Idle timeout: eight quiet cycles after a handshake, then power-down
    applyStimulus(1'b1, 1'b1, ADDR_W'(20), 16'h1234);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("idle_chip_en_%0d", k), 32'(mem_if.chip_en), 32'd1);
      nextCycle();
    end
    checkOutput("timeout_chip_en", 32'(mem_if.chip_en), 32'd0);
    checkOutput("timeout_state", 32'(dut.state), 32'(OFF));
    checkOutput("timeout_req_ready", 32'(req_ready), 32'd0);

    // Request arriving on the expiry cycle keeps the bank on
    applyStimulus(1'b1, 1'b1, ADDR_W'(21), 16'h5678);
    nextCycle();
    nextCycle();
    checkOutput("rewake_handshake", 32'(mem_if.wr_en), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int k = 1; k < 8; k++) nextCycle();
    checkOutput("expiry_chip_en", 32'(mem_if.chip_en), 32'd1);
    applyStimulus(1'b1, 1'b0, ADDR_W'(20), '0);
    checkOutput("expiry_rd_en", 32'(mem_if.rd_en), 32'd1);
    checkOutput("expiry_rd_addr", 32'(mem_if.rd_addr), 32'd20);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("expiry_state", 32'(dut.state), 32'(ON));
    checkOutput("expiry_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("expiry_rsp_data", 32'(rsp_data), 32'h1234);

    // Reset with a response pending
    applyStimulus(1'b1, 1'b0, ADDR_W'(12), '0);
    nextCycle();
    checkOutput("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mid_reset_chip_en", 32'(mem_if.chip_en), 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post_reset_state", 32'(dut.state), 32'(OFF));
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd0);

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
    // Out-of-range read is accepted but never reaches the bank
    applyStimulus(1'b1, 1'b0, ADDR_W'(1000), '0);
    nextCycle();
    nextCycle();
    checkOutput("oob_req_ready", 32'(req_ready), 32'd1);
    checkOutput("oob_rd_en", 32'(mem_if.rd_en), 32'd0);
    checkOutput("oob_wr_en", 32'(mem_if.wr_en), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("oob_bounds_err", 32'(bounds_err), 32'd1);
    checkOutput("oob_rsp_valid", 32'(rsp_valid), 32'd0);
    nextCycle();
    checkOutput("oob_bounds_err_end", 32'(bounds_err), 32'd0);
`endif

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
